// File: rtl/attex_bus_matrix.sv
`timescale 1ns/1ps
// attex_bus_matrix
// SCC68070 bus decoder/responder. Maps CPU byte addresses onto mask/base
// windows, routes each hit to one peripheral port, muxes read data and
// acknowledge back to the CPU, answers interrupt-acknowledge cycles and
// raises bus error on unmapped or timed-out cycles.
module attex_bus_matrix #(
    parameter int NUM_TARGETS = 5,
    parameter int NUM_REGIONS = 8,
    parameter logic [NUM_REGIONS*24-1:0] REGION_BASE = {
        24'h400000, 24'h200000, 24'h000000, 24'hE80000,
        24'hD00000, 24'h320000, 24'h300000, 24'h310000},
    parameter logic [NUM_REGIONS*24-1:0] REGION_MASK = {
        24'hC00000, 24'hF80000, 24'hE00000, 24'hF80000,
        24'hF00000, 24'hFF0000, 24'hFF0000, 24'hFF0000},
    parameter logic [NUM_REGIONS*8-1:0] REGION_TGT = {
        8'd4, 8'd4, 8'd4, 8'd3, 8'd3, 8'd2, 8'd1, 8'd0},
    parameter int TIMEOUT_CYCLES = 1024,
    localparam int TSW = (NUM_TARGETS > 1) ? $clog2(NUM_TARGETS) : 1
) (
    input  logic                      clk30,
    input  logic                      reset,
    input  logic [23:1]               cpu_addr,
    input  logic                      cpu_as,
    input  logic                      cpu_uds,
    input  logic                      cpu_lds,
    input  logic                      cpu_write_strobe,
    output logic [15:0]               cpu_din,
    output logic                      cpu_bus_ack,
    output logic                      cpu_bus_err,
    input  logic                      iack_valid,
    input  logic [TSW-1:0]            iack_tgt,
    output logic [NUM_TARGETS-1:0]    tgt_cs,
    output logic [NUM_TARGETS-1:0]    tgt_sel_pulse,
    input  logic [NUM_TARGETS*16-1:0] tgt_dout,
    input  logic [NUM_TARGETS-1:0]    tgt_ack,
    output logic [7:0]                err_count
);

    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_ERROR  = 2'd2,
        ST_DRAIN  = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [TW-1:0]          timer_q, timer_d;
    logic [7:0]             err_count_q, err_count_d;
    logic [NUM_TARGETS-1:0] tgt_cs_q, tgt_cs_d;

    logic [23:0]            byte_addr;
    logic                   region_hit;
    logic [7:0]             region_tgt;
    logic [NUM_TARGETS-1:0] sel_onehot;
    logic                   hit_any;
    logic [15:0]            dec_din;
    logic                   dec_ack;
    logic [15:0]            iack_din;
    logic                   lanes;
    logic [31:0]            timer_inc;
    logic                   unused_inputs;

    // Direction of the cycle does not change how it is decoded or completed.
    assign unused_inputs = cpu_write_strobe;
    assign byte_addr     = {cpu_addr, 1'b0};
    assign lanes         = cpu_uds | cpu_lds;
    assign timer_inc     = 32'(timer_q) + 32'd1;

    // Window decode: scan from the highest index down so the lowest hit wins.
    always_comb begin
        region_hit = 1'b0;
        region_tgt = 8'd0;
        for (int r = NUM_REGIONS - 1; r >= 0; r--) begin
            if ((byte_addr & REGION_MASK[r*24 +: 24]) == REGION_BASE[r*24 +: 24]) begin
                region_hit = 1'b1;
                region_tgt = REGION_TGT[r*8 +: 8];
            end
        end
    end

    // Turn the selected target into a one-hot vector and pick its data/ack;
    // a window pointing at a nonexistent port behaves as unmapped.
    always_comb begin
        sel_onehot = '0;
        dec_din    = 16'h0000;
        dec_ack    = 1'b0;
        iack_din   = 16'h0000;
        for (int t = 0; t < NUM_TARGETS; t++) begin
            if (region_hit && (region_tgt == 8'(t))) begin
                sel_onehot[t] = 1'b1;
                dec_din       = tgt_dout[t*16 +: 16];
                dec_ack       = tgt_ack[t];
            end
            if (iack_tgt == TSW'(t)) begin
                iack_din = tgt_dout[t*16 +: 16];
            end
        end
    end

    assign hit_any = |sel_onehot;

    // CPU-facing responses; IACK overrides normal decode, and an idle bus never stalls.
    always_comb begin
        tgt_cs      = '0;
        cpu_din     = 16'h0000;
        cpu_bus_ack = 1'b0;
        if (cpu_as && !iack_valid && (state_q != ST_ERROR)) begin
            tgt_cs = sel_onehot;
        end
        if (iack_valid) begin
            cpu_din = iack_din;
        end else if (cpu_as) begin
            cpu_din = dec_din;
        end
        if (iack_valid) begin
            cpu_bus_ack = 1'b1;
        end else if (state_q == ST_ERROR) begin
            cpu_bus_ack = 1'b0;
        end else if (!cpu_as || !lanes) begin
            cpu_bus_ack = 1'b1;
        end else if ((state_q == ST_ACTIVE) || (state_q == ST_DRAIN)) begin
            cpu_bus_ack = dec_ack;
        end
    end

    assign tgt_sel_pulse = tgt_cs & ~tgt_cs_q;
    assign tgt_cs_d      = tgt_cs;
    assign cpu_bus_err   = (state_q == ST_ERROR);
    assign err_count     = err_count_q;

    // Cycle tracking: start, wait for ack or timeout, then hold until as drops.
    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        err_count_d = err_count_q;
        case (state_q)
            ST_IDLE: begin
                if (cpu_as && lanes && !iack_valid) begin
                    if (hit_any) begin
                        state_d = ST_ACTIVE;
                        timer_d = '0;
                    end else begin
                        state_d = ST_ERROR;
                    end
                end
            end
            ST_ACTIVE: begin
                if (!cpu_as) begin
                    state_d = ST_IDLE;
                end else if (dec_ack) begin
                    state_d = ST_DRAIN;
                end else if ((TIMEOUT_CYCLES != 0) &&
                             (timer_inc >= 32'(TIMEOUT_CYCLES - 1))) begin
                    state_d = ST_ERROR;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            ST_ERROR: begin
                if (!cpu_as) begin
                    state_d = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (!cpu_as) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if ((state_d == ST_ERROR) && (state_q != ST_ERROR) && (err_count_q != 8'hFF)) begin
            err_count_d = err_count_q + 8'd1;
        end
    end

    // State registers with synchronous reset; reset abandons any open cycle.
    always_ff @(posedge clk30) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            timer_q     <= '0;
            err_count_q <= 8'h00;
            tgt_cs_q    <= '0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            err_count_q <= err_count_d;
            tgt_cs_q    <= tgt_cs_d;
        end
    end

endmodule

// File: tb/tb_attex_bus_matrix.sv
`timescale 1ns/1ps
// tb_attex_bus_matrix
// Directed vectors against the default CD-i memory map with hand-computed
// expectations for decode, read mux, ack timing, errors, IACK and reset.
module tb_attex_bus_matrix;

    localparam int NT      = 5;
    localparam int TIMEOUT = 1024;

    logic          clk30;
    logic          reset;
    logic [23:1]   cpu_addr;
    logic          cpu_as;
    logic          cpu_uds;
    logic          cpu_lds;
    logic          cpu_write_strobe;
    logic [15:0]   cpu_din;
    logic          cpu_bus_ack;
    logic          cpu_bus_err;
    logic          iack_valid;
    logic [2:0]    iack_tgt;
    logic [NT-1:0] tgt_cs;
    logic [NT-1:0] tgt_sel_pulse;
    logic [NT*16-1:0] tgt_dout;
    logic [NT-1:0] tgt_ack;
    logic [7:0]    err_count;

    int assertCount = 0;
    int failCount   = 0;

    attex_bus_matrix #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
        .clk30            (clk30),
        .reset            (reset),
        .cpu_addr         (cpu_addr),
        .cpu_as           (cpu_as),
        .cpu_uds          (cpu_uds),
        .cpu_lds          (cpu_lds),
        .cpu_write_strobe (cpu_write_strobe),
        .cpu_din          (cpu_din),
        .cpu_bus_ack      (cpu_bus_ack),
        .cpu_bus_err      (cpu_bus_err),
        .iack_valid       (iack_valid),
        .iack_tgt         (iack_tgt),
        .tgt_cs           (tgt_cs),
        .tgt_sel_pulse    (tgt_sel_pulse),
        .tgt_dout         (tgt_dout),
        .tgt_ack          (tgt_ack),
        .err_count        (err_count)
    );

    // Free-running 100 MHz-style clock; only relative timing matters here.
    initial clk30 = 1'b0;
    always #5 clk30 = ~clk30;

    // Hard stop in case some wait never completes.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] simulation time limit reached");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
        end
    endtask

    // Drive a new bus state just after a falling edge, then let it settle.
    task automatic applyStimulus(input logic as, input logic uds, input logic lds,
                                 input logic we, input logic [23:0] byteAddr);
        @(negedge clk30);
        cpu_as           = as;
        cpu_uds          = uds;
        cpu_lds          = lds;
        cpu_write_strobe = we;
        cpu_addr         = byteAddr[23:1];
        #1;
    endtask

    task automatic tick();
        @(negedge clk30);
        #1;
    endtask

    typedef struct {
        logic [23:0]   addr;
        logic [NT-1:0] cs;
        logic [15:0]   din;
    } decodeVec_t;

    decodeVec_t decodeTable[7];
    int errCycle;

    initial begin
        decodeTable[0] = '{24'h0A0000, 5'b10000, 16'h4444};
        decodeTable[1] = '{24'h27FFFE, 5'b10000, 16'h4444};
        decodeTable[2] = '{24'h7FFFFE, 5'b10000, 16'h4444};
        decodeTable[3] = '{24'hD12344, 5'b01000, 16'h3333};
        decodeTable[4] = '{24'hE80000, 5'b01000, 16'h3333};
        decodeTable[5] = '{24'h310000, 5'b00001, 16'h1000};
        decodeTable[6] = '{24'h320000, 5'b00100, 16'h2222};

        reset            = 1'b1;
        cpu_addr         = '0;
        cpu_as           = 1'b0;
        cpu_uds          = 1'b0;
        cpu_lds          = 1'b0;
        cpu_write_strobe = 1'b0;
        iack_valid       = 1'b0;
        iack_tgt         = 3'd0;
        tgt_ack          = '0;
        tgt_dout         = {16'h4444, 16'h3333, 16'h2222, 16'hA55A, 16'h1000};
        tick();
        tick();
        checkOutput("rstErr",   32'(cpu_bus_err),   32'h0);
        checkOutput("rstCount", 32'(err_count),     32'h0);
        checkOutput("rstPulse", 32'(tgt_sel_pulse), 32'h0);
        checkOutput("rstAck",   32'(cpu_bus_ack),   32'h1);
        checkOutput("rstDin",   32'(cpu_din),       32'h0);
        checkOutput("rstCs",    32'(tgt_cs),        32'h0);
        @(negedge clk30);
        reset = 1'b0;
        tick();

        // Write to the slave port, acknowledged in the third cycle.
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 24'h310002);
        checkOutput("wrCs",      32'(tgt_cs),        32'h01);
        checkOutput("wrPulse",   32'(tgt_sel_pulse), 32'h01);
        checkOutput("wrAckWait", 32'(cpu_bus_ack),   32'h0);
        tick();
        checkOutput("wrPulseOnce", 32'(tgt_sel_pulse), 32'h00);
        checkOutput("wrAckLow",    32'(cpu_bus_ack),   32'h0);
        tick();
        @(negedge clk30);
        tgt_ack = 5'b00001;
        #1;
        checkOutput("wrAck", 32'(cpu_bus_ack), 32'h1);
        checkOutput("wrErr", 32'(cpu_bus_err), 32'h0);
        tick();
        checkOutput("wrDrainAck", 32'(cpu_bus_ack), 32'h1);
        tgt_ack = '0;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 24'h310002);
        tick();
        checkOutput("wrCount", 32'(err_count), 32'h0);

        // Read from CDIC with ack one cycle after the strobe.
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 24'h300000);
        checkOutput("rdCs",  32'(tgt_cs),  32'h02);
        checkOutput("rdDin", 32'(cpu_din), 32'hA55A);
        @(negedge clk30);
        tgt_ack = 5'b00010;
        #1;
        checkOutput("rdAck",    32'(cpu_bus_ack), 32'h1);
        checkOutput("rdDinAck", 32'(cpu_din),     32'hA55A);
        tgt_ack = '0;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 24'h300000);
        tick();

        // Address strobe without lanes must not stall the bus.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 24'h320000);
        checkOutput("noLaneAck", 32'(cpu_bus_ack), 32'h1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 24'h320000);
        tick();

        // Window table, including the three MCD212 windows.
        foreach (decodeTable[i]) begin
            applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, decodeTable[i].addr);
            checkOutput($sformatf("decCs%0d", i),  32'(tgt_cs),  32'(decodeTable[i].cs));
            checkOutput($sformatf("decDin%0d", i), 32'(cpu_din), 32'(decodeTable[i].din));
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, decodeTable[i].addr);
            tick();
        end

        // Unmapped access. 0x500000 lies inside the 0x400000/0xC00000 window,
        // so the probe uses 0x900000, which no window covers.
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 24'h900000);
        checkOutput("unmCs",     32'(tgt_cs),      32'h0);
        checkOutput("unmDin",    32'(cpu_din),     32'h0);
        checkOutput("unmErrNow", 32'(cpu_bus_err), 32'h0);
        tick();
        checkOutput("unmErr",   32'(cpu_bus_err), 32'h1);
        checkOutput("unmAck",   32'(cpu_bus_ack), 32'h0);
        checkOutput("unmCount", 32'(err_count),   32'h1);
        tick();
        checkOutput("unmErrHold",  32'(cpu_bus_err), 32'h1);
        checkOutput("unmCountOne", 32'(err_count),   32'h1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 24'h900000);
        tick();
        checkOutput("unmErrClr", 32'(cpu_bus_err), 32'h0);
        checkOutput("unmIdleAck", 32'(cpu_bus_ack), 32'h1);

        // NVRAM never acknowledges; error must appear TIMEOUT cycles after the strobe.
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 24'h320000);
        checkOutput("toCs", 32'(tgt_cs), 32'h04);
        errCycle = -1;
        for (int k = 1; k <= TIMEOUT + 50 && errCycle < 0; k++) begin
            tick();
            if (cpu_bus_err) errCycle = k;
        end
        checkOutput("toCycle", 32'(errCycle), 32'(TIMEOUT));
        checkOutput("toCsOff", 32'(tgt_cs),   32'h0);
        tick();
        checkOutput("toCount", 32'(err_count), 32'h2);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 24'h320000);
        tick();

        // Interrupt acknowledge: vector from CDIC, no chip selects.
        tgt_dout[16 +: 16] = 16'h0047;
        iack_valid = 1'b1;
        iack_tgt   = 3'd1;
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 24'h310000);
        checkOutput("iackDin", 32'(cpu_din),     32'h0047);
        checkOutput("iackAck", 32'(cpu_bus_ack), 32'h1);
        checkOutput("iackCs",  32'(tgt_cs),      32'h0);
        tick();
        checkOutput("iackErr", 32'(cpu_bus_err), 32'h0);
        iack_valid = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 24'h310000);
        tick();

        // Reset in the middle of a long wait abandons the cycle silently.
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 24'h320000);
        for (int k = 0; k < 500; k++) tick();
        checkOutput("midErrPre", 32'(cpu_bus_err), 32'h0);
        @(negedge clk30);
        reset   = 1'b1;
        cpu_as  = 1'b0;
        cpu_uds = 1'b0;
        cpu_lds = 1'b0;
        tick();
        checkOutput("midCount", 32'(err_count),   32'h0);
        checkOutput("midAck",   32'(cpu_bus_ack), 32'h1);
        @(negedge clk30);
        reset = 1'b0;
        for (int k = 0; k < 20; k++) tick();
        checkOutput("midErr",   32'(cpu_bus_err), 32'h0);
        checkOutput("midCount2", 32'(err_count),  32'h0);

        // Error counter saturates at 0xFF.
        for (int k = 0; k < 300; k++) begin
            applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 24'h900000);
            tick();
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 24'h900000);
            tick();
            if (k == 9) checkOutput("satCount10", 32'(err_count), 32'h0A);
        end
        checkOutput("satCount", 32'(err_count), 32'hFF);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
